// File: rtl/uart_fifo_tx_ctrl.sv
// uart_fifo_tx_ctrl: pops bytes from the UART FIFO and hands them to the byte transmitter (streaming or burst).
// Optional `define UART_TX_CTRL_TIMEOUT_EN: flushes stale sub-threshold burst data after TIMEOUT_CYCLES idle clocks.
module uart_fifo_tx_ctrl #(
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             burst_mode,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic             fifo_thr_trigger,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_pop,
  input  logic             tx_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             drain_done,
  output logic [CNT_W-1:0] bytes_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_CAPTURE,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t           state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [CNT_W-1:0] bytes_sent_q, bytes_sent_d;
  logic             flush_pend_q, flush_pend_d;
  logic             draining_q, draining_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             timeout_hit;
  logic             next_byte;

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    bytes_sent_d = bytes_sent_q;
    draining_d   = draining_q;
    gap_cnt_d    = gap_cnt_q;
    flush_pend_d = flush_pend_q | flush | timeout_hit;
    fifo_pop     = 1'b0;
    tx_start     = 1'b0;
    drain_done   = 1'b0;
    next_byte    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fifo_empty && (flush_pend_q || draining_q)) begin
          drain_done   = 1'b1;
          flush_pend_d = 1'b0;
          draining_d   = 1'b0;
        end else if (en && !fifo_empty &&
                     (!burst_mode || fifo_thr_trigger || flush_pend_q || draining_q)) begin
          state_d    = S_POP;
          draining_d = burst_mode | flush_pend_q | draining_q;
        end
      end
      S_POP: begin
        fifo_pop = 1'b1;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        tx_data_d = fifo_dout;
        state_d   = S_SEND;
      end
      S_SEND: begin
        tx_start = tx_ready;
        if (tx_ready) begin
          bytes_sent_d = bytes_sent_q + CNT_W'(1);
          if (GAP_CYCLES > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = 8'd0;
          end else begin
            next_byte = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) next_byte = 1'b1;
        else                       gap_cnt_d = gap_cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // A drain was entered only in burst/flush context and streaming always continues,
    // so burst_mode itself is not re-sampled until the FSM is back in IDLE.
    if (next_byte) begin
      state_d = (en && !fifo_empty) ? S_POP : S_IDLE;
      if (draining_q && fifo_empty) begin
        drain_done   = 1'b1;
        draining_d   = 1'b0;
        flush_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tx_data_q    <= 8'd0;
      bytes_sent_q <= '0;
      flush_pend_q <= 1'b0;
      draining_q   <= 1'b0;
      gap_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      bytes_sent_q <= bytes_sent_d;
      flush_pend_q <= flush_pend_d;
      draining_q   <= draining_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

`ifdef UART_TX_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_run;

  // Runs only while sub-threshold data sits in IDLE; any other condition restarts it.
  always_comb begin
    to_run      = (state_q == S_IDLE) && burst_mode && !fifo_empty && !fifo_thr_trigger;
    to_cnt_d    = '0;
    timeout_hit = 1'b0;
    if (to_run) begin
      if (to_cnt_q == TO_LAST) timeout_hit = 1'b1;
      else                     to_cnt_d    = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  assign tx_data    = tx_data_q;
  assign bytes_sent = bytes_sent_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_fifo_tx_ctrl.md
Name: uart_fifo_tx_ctrl

Overview:
Drain sequencer between the UART FIFO read side and the UART byte transmitter. It pops bytes from the FIFO, captures the registered FIFO output, and hands each byte to the transmitter using a ready/start handshake. Two modes: streaming (send whenever data exists) and burst (wait for the FIFO threshold trigger, then drain to empty). Software flush forces a drain in either mode.

Parameters:
GAP_CYCLES, 0, idle clock cycles inserted after each accepted byte before the next pop (0..255)
TIMEOUT_CYCLES, 1000, burst-mode stale-data timeout in clocks (used only with the optional feature)
CNT_W, 16, width of the bytes_sent counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  controller enable
burst_mode  in  1  0 = streaming, 1 = threshold-triggered burst
flush  in  1  single-cycle request to drain FIFO to empty
fifo_empty  in  1  FIFO empty flag
fifo_thr_trigger  in  1  FIFO level >= threshold
fifo_dout  in  8  FIFO read data, valid the cycle after fifo_pop
fifo_pop  out  1  one-cycle FIFO pop strobe
tx_ready  in  1  transmitter can accept a byte
tx_start  out  1  one-cycle strobe, tx_data accepted this cycle
tx_data  out  8  byte to transmit, held stable from CAPTURE until accepted
busy  out  1  FSM not in IDLE
drain_done  out  1  one-cycle pulse when a burst or flush drain finishes
bytes_sent  out  CNT_W  count of bytes accepted by transmitter, wraps at 2^CNT_W

Behaviour:
- Reset (async): state=IDLE. fifo_pop, tx_start, busy, drain_done, tx_data, bytes_sent, flush_pend, draining, gap counter all 0. A byte in flight is discarded.
- flush sets flush_pend (sticky), cleared at drain_done. flush during a drain is absorbed.
- FSM states: IDLE, POP, CAPTURE, SEND, GAP.
- IDLE -> POP when en & !fifo_empty & (burst_mode==0 | fifo_thr_trigger | flush_pend).
  - On entry, draining=1 if burst_mode | flush_pend.
  - If flush_pend & fifo_empty: pulse drain_done, clear flush_pend, stay IDLE.
- POP: fifo_pop=1 for exactly one cycle -> CAPTURE. fifo_pop is never asserted while fifo_empty=1 (no underrun by construction).
- CAPTURE: tx_data <= fifo_dout -> SEND.
- SEND: tx_start = tx_ready (combinational in state, one cycle). Wait in SEND while tx_ready=0.
  - On accept: bytes_sent+1, go to GAP if GAP_CYCLES>0, else take the next-byte decision.
- GAP: count GAP_CYCLES clocks, then take the next-byte decision.
- Next-byte decision:
  - if en & !fifo_empty & (draining | burst_mode==0) -> POP
  - else -> IDLE
  - if draining & fifo_empty: pulse drain_done, clear draining and flush_pend
- Latency: IDLE with data -> tx_start = 3 cycles minimum (POP, CAPTURE, SEND with tx_ready=1). Back-to-back bytes: one byte per 3+GAP_CYCLES cycles.
- en deassert mid-byte: the current byte completes through SEND; no further pops; draining retained; resumes when en=1.
- burst_mode change mid-drain: ignored until return to IDLE.
- busy = (state != IDLE).

Optional Feature:
UART_TX_CTRL_TIMEOUT_EN
- Defined: in IDLE with burst_mode=1, !fifo_empty and !fifo_thr_trigger, a counter runs. On reaching TIMEOUT_CYCLES it sets flush_pend, forcing a drain that ends with drain_done. The counter clears on any pop, on fifo_empty, or when leaving IDLE.
- Undefined: no counter. Burst mode holds sub-threshold data indefinitely until threshold or flush.

Test Plan:
- Streaming, GAP_CYCLES=0, tx_ready=1, FIFO preloaded 0x11,0x22,0x33 -> tx_start on cycles 3, 6, 9 with tx_data 0x11/0x22/0x33; bytes_sent=3; busy drops after the last byte; drain_done never pulses.
- Burst, threshold 4'hA, push 9 bytes -> no fifo_pop; push 10th (thr_trigger=1) -> all 10 bytes sent in order; drain_done pulses once when fifo_empty.
- tx_ready held 0 for 20 cycles in SEND -> tx_start stays 0, tx_data stable; tx_ready=1 -> single tx_start; no extra pop.
- Burst, 4 bytes, flush pulse -> 4 bytes sent, drain_done one pulse. Flush with FIFO empty -> drain_done next cycle, no pop.
- Reset asserted mid-SEND after 2 of 5 bytes -> all outputs 0 immediately; bytes_sent=0; after release, streaming resumes from the remaining FIFO contents.
- With UART_TX_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=50, burst mode, 3 bytes -> drain starts 50 cycles after the last push; 3 bytes sent; drain_done pulses.
